// File: rtl/word_tokenizer_pkg.sv
// Shared types and constants for the word tokenizer: token kinds, FSM states,
// character codes and small helper functions.
package word_tok_pkg;

  typedef enum logic [1:0] {
    KIND_OTHER = 2'b00,
    KIND_BEGIN = 2'b01,
    KIND_END   = 2'b10,
    KIND_EOS   = 2'b11
  } tok_kind_e;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    B1   = 4'd1,
    B2   = 4'd2,
    B3   = 4'd3,
    B4   = 4'd4,
    B5   = 4'd5,
    E1   = 4'd6,
    E2   = 4'd7,
    E3   = 4'd8,
    OTH  = 4'd9
  } tok_state_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_D     = 8'h64;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] LEN_MAX  = 8'hFF;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if ((c >= 8'h41) && (c <= 8'h5A)) begin
      return c | 8'h20;
    end else begin
      return c;
    end
  endfunction

  function automatic logic [7:0] len_inc(input logic [7:0] l);
    return (l == LEN_MAX) ? LEN_MAX : (l + 8'd1);
  endfunction

  // Only a fully matched keyword classifies; every other word is OTHER.
  function automatic tok_kind_e word_kind(input tok_state_e s);
    case (s)
      B5:      return KIND_BEGIN;
      E3:      return KIND_END;
      default: return KIND_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/word_tokenizer_if.sv
// Character-in / token-out handshake bundle of the word tokenizer.
// tok_len exists only when TOKENIZER_LEN_EN is defined.
interface word_tokenizer_if;
  import word_tok_pkg::*;

  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       tok_valid;
  tok_kind_e  tok_kind;
  logic       tok_ready;
`ifdef TOKENIZER_LEN_EN
  logic [7:0] tok_len;

  modport master (
    output in_valid, in_char, tok_ready,
    input  in_ready, tok_valid, tok_kind, tok_len
  );

  modport slave (
    input  in_valid, in_char, tok_ready,
    output in_ready, tok_valid, tok_kind, tok_len
  );
`else
  modport master (
    output in_valid, in_char, tok_ready,
    input  in_ready, tok_valid, tok_kind
  );

  modport slave (
    input  in_valid, in_char, tok_ready,
    output in_ready, tok_valid, tok_kind
  );
`endif

endinterface

// File: rtl/word_tokenizer_tok_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; full/empty come from
// comparing the pointer MSBs. DEPTH must be a power of two, >= 2.
module tok_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update; storage is cleared so the idle head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/word_tokenizer.sv
// Splits a char stream into space-separated words and emits one classified
// token (OTHER/BEGIN/END/EOS) per word. Optional macro TOKENIZER_LEN_EN adds tok_len.
module word_tokenizer
  import word_tok_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  word_tokenizer_if.slave   bus
);

`ifdef TOKENIZER_LEN_EN
  localparam int unsigned FIFO_W = 10;
`else
  localparam int unsigned FIFO_W = 2;
`endif

  tok_state_e        state_r;
  tok_state_e        state_s;
  logic              eos_pend_r;
  logic              eos_set_s;
  logic              eos_clr_s;
  logic              push_s;
  tok_kind_e         push_kind_s;
  logic [FIFO_W-1:0] push_data_s;
  logic [FIFO_W-1:0] head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              word_char_s;
  logic [7:0]        char_s;

  assign in_ready_s  = !reset && !fifo_full_s && !eos_pend_r;
  assign accept_s    = bus.in_valid && in_ready_s;
  assign char_s      = fold_case(bus.in_char);
  assign word_char_s = (char_s != CH_SPACE) && (char_s != CH_NUL);

  assign bus.in_ready  = in_ready_s;
  assign bus.tok_valid = !fifo_empty_s;
  assign bus.tok_kind  = tok_kind_e'(head_s[1:0]);

  // FSM state and deferred-EOS flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      eos_pend_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (eos_set_s) begin
        eos_pend_r <= 1'b1;
      end else if (eos_clr_s) begin
        eos_pend_r <= 1'b0;
      end else begin
        eos_pend_r <= eos_pend_r;
      end
    end
  end

  // Next state and token push; a pending EOS owns the push slot until it lands.
  always_comb begin
    state_s     = state_r;
    push_s      = 1'b0;
    push_kind_s = KIND_OTHER;
    eos_set_s   = 1'b0;
    eos_clr_s   = 1'b0;
    if (eos_pend_r) begin
      if (!fifo_full_s) begin
        push_s      = 1'b1;
        push_kind_s = KIND_EOS;
        eos_clr_s   = 1'b1;
      end else begin
        push_s = 1'b0;
      end
    end else if (accept_s) begin
      if (char_s == CH_NUL) begin
        push_s  = 1'b1;
        state_s = IDLE;
        if (state_r == IDLE) begin
          push_kind_s = KIND_EOS;
        end else begin
          push_kind_s = word_kind(state_r);
          eos_set_s   = 1'b1;
        end
      end else if (char_s == CH_SPACE) begin
        state_s = IDLE;
        if (state_r != IDLE) begin
          push_s      = 1'b1;
          push_kind_s = word_kind(state_r);
        end else begin
          push_s = 1'b0;
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (char_s == CH_B) begin
              state_s = B1;
            end else if (char_s == CH_E) begin
              state_s = E1;
            end else begin
              state_s = OTH;
            end
          end
          B1:      state_s = (char_s == CH_E) ? B2 : OTH;
          B2:      state_s = (char_s == CH_G) ? B3 : OTH;
          B3:      state_s = (char_s == CH_I) ? B4 : OTH;
          B4:      state_s = (char_s == CH_N) ? B5 : OTH;
          E1:      state_s = (char_s == CH_N) ? E2 : OTH;
          E2:      state_s = (char_s == CH_D) ? E3 : OTH;
          default: state_s = OTH;
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

`ifdef TOKENIZER_LEN_EN
  logic [7:0] len_r;

  // Word length; a word char seen in IDLE starts a fresh count at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_r <= 8'd0;
    end else if (accept_s) begin
      if (word_char_s) begin
        len_r <= len_inc((state_r == IDLE) ? 8'd0 : len_r);
      end else begin
        len_r <= 8'd0;
      end
    end else begin
      len_r <= len_r;
    end
  end

  assign push_data_s = {((push_kind_s == KIND_EOS) ? 8'd0 : len_r), push_kind_s};
  assign bus.tok_len = head_s[9:2];
`else
  assign push_data_s = push_kind_s;
`endif

  tok_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (bus.tok_ready),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

endmodule

// File: tb/tb_word_tokenizer.sv
// Directed self-checking bench for word_tokenizer; the tok_len scenarios run
// only when TOKENIZER_LEN_EN is defined.
module tb_word_tokenizer;
  import word_tok_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  word_tokenizer_if tif ();

  word_tokenizer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [1:0] got_kind [$];
  int         got_cyc  [$];
  logic [7:0] got_len  [$];
  logic [1:0] exp_kind [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Token monitor: records every head that will pop at the coming edge.
  always @(negedge clk) begin
    if (!reset && tif.tok_valid && tif.tok_ready) begin
      got_kind.push_back(tif.tok_kind);
      got_cyc.push_back(cyc);
`ifdef TOKENIZER_LEN_EN
      got_len.push_back(tif.tok_len);
`else
      got_len.push_back(8'd0);
`endif
    end
  end

  // Must be called just after a rising edge (#1).
  task automatic send(input logic [7:0] c);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    tif.in_valid = 1'b1;
    tif.in_char  = c;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (tif.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    tif.in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_tokens(input string tag);
    check({tag, "_count"}, got_kind.size(), exp_kind.size());
    for (int i = 0; i < exp_kind.size(); i++) begin
      if (i < got_kind.size()) check($sformatf("%s_tok%0d", tag, i), got_kind[i], exp_kind[i]);
    end
    got_kind.delete();
    got_cyc.delete();
    got_len.delete();
    exp_kind.delete();
  endtask

  initial begin
    tif.in_valid  = 1'b0;
    tif.in_char   = 8'h00;
    tif.tok_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_held", tif.in_ready, 1'b0);
    check("rst_tok_valid_held", tif.tok_valid, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", tif.in_ready, 1'b1);
    check("rst_tok_valid", tif.tok_valid, 1'b0);
`ifdef TOKENIZER_LEN_EN
    check("rst_tok_len", tif.tok_len, 8'd0);
`endif
    @(posedge clk);
    #1;

    // 1: keywords, repeated space yields nothing
    send_str("begin end  ");
    drain(4);
    exp_kind = '{2'b01, 2'b10};
    check_tokens("t1");

    // 2: case-fold, prefix and overlong word
    send_str("BeGiN  be beginx ");
    drain(4);
    exp_kind = '{2'b01, 2'b00, 2'b00};
    check_tokens("t2");

    // 3: NUL mid-word gives word token then EOS one cycle later
    send_str("end");
    send(8'h00);
    @(negedge clk);
    check("t3_in_ready_low", tif.in_ready, 1'b0);
    @(negedge clk);
    check("t3_in_ready_back", tif.in_ready, 1'b1);
    drain(4);
    if (got_cyc.size() >= 2) check("t3_eos_gap", got_cyc[1] - got_cyc[0], 32'd1);
    exp_kind = '{2'b10, 2'b11};
    check_tokens("t3");

    // 4: backpressure fills the FIFO
    tif.tok_ready = 1'b0;
    send_str("a b c d ");
    @(negedge clk);
    check("t4_in_ready_full", tif.in_ready, 1'b0);
    check("t4_tok_valid", tif.tok_valid, 1'b1);
    check("t4_no_pop", got_kind.size(), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t4_in_ready_stays", tif.in_ready, 1'b0);
    @(posedge clk);
    #1 tif.tok_ready = 1'b1;
    @(negedge clk);
    check("t4_in_ready_before_pop", tif.in_ready, 1'b0);
    @(negedge clk);
    check("t4_in_ready_rise", tif.in_ready, 1'b1);
    @(posedge clk);
    #1;
    send_str("e ");
    drain(8);
    exp_kind = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    check_tokens("t4");

    // 5: reset mid-word discards the partial word
    send_str("beg");
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t5_tok_valid", tif.tok_valid, 1'b0);
    check("t5_in_ready", tif.in_ready, 1'b1);
    @(posedge clk);
    #1;
    send_str("in ");
    drain(4);
    exp_kind = '{2'b00};
    check_tokens("t5");

`ifdef TOKENIZER_LEN_EN
    // 6: word length, saturation, EOS length
    send_str("hello ");
    for (int i = 0; i < 300; i++) send(8'h78);
    send(8'h20);
    send(8'h00);
    drain(4);
    if (got_len.size() >= 3) begin
      check("t6_len_hello", got_len[0], 8'd5);
      check("t6_len_sat", got_len[1], 8'd255);
      check("t6_len_eos", got_len[2], 8'd0);
    end
    exp_kind = '{2'b00, 2'b00, 2'b11};
    check_tokens("t6");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
